// File: rtl/ball_path_walker.sv
// Walks a ball sprite position along a list of path nodes, one pixel per
// step period, dwelling one step at each node before heading to the next.
module ball_path_walker #(
  parameter int unsigned NODES    = 20,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic [4:0]            node_count,
  input  logic [10*NODES-1:0]   nodes_x,
  input  logic [10*NODES-1:0]   nodes_y,
  output logic [9:0]            next_x,
  output logic [9:0]            next_y,
  output logic [4:0]            node_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, LOAD, MOVE, FINISH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

  state_t     state_q;
  logic [9:0] x_q, y_q, tx_q, ty_q;
  logic [4:0] idx_q, cnt_q;
  logic [7:0] div_q;
  logic       busy_q, done_q;

  logic       step_en, at_target, last_hop;
  logic [5:0] tgt_i;
  logic [9:0] tgt_x, tgt_y, n0_x, n0_y, step_x, step_y;
  logic [4:0] cnt_eff;

  // Out-of-range node indices read as zero so LOAD may safely fetch node 1.
  function automatic logic [9:0] pick(input logic [10*NODES-1:0] v, input logic [5:0] i);
    logic [9:0] r;
    r = '0;
    if (32'(i) < NODES) r = v[10*i +: 10];
    return r;
  endfunction

  always_comb begin
    step_en   = tick && !pause && (state_q == MOVE) && (div_q == DIV_LAST);
    at_target = (x_q == tx_q) && (y_q == ty_q);
    last_hop  = (idx_q + 5'd1) == (cnt_q - 5'd1);
    tgt_i     = (state_q == LOAD) ? 6'd1 : 6'(idx_q) + 6'd2;
    tgt_x     = pick(nodes_x, tgt_i);
    tgt_y     = pick(nodes_y, tgt_i);
    n0_x      = nodes_x[9:0];
    n0_y      = nodes_y[9:0];
    cnt_eff   = (32'(node_count) > NODES) ? 5'(NODES) : node_count;

    step_x = x_q;
    if (x_q < tx_q)      step_x = x_q + 10'd1;
    else if (x_q > tx_q) step_x = x_q - 10'd1;
    step_y = y_q;
    if (y_q < ty_q)      step_y = y_q + 10'd1;
    else if (y_q > ty_q) step_y = y_q - 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= cnt_eff;
            div_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_q != 5'd0) begin
            x_q <= n0_x;
            y_q <= n0_y;
          end
          idx_q   <= '0;
          busy_q  <= 1'b1;
          tx_q    <= tgt_x;
          ty_q    <= tgt_y;
          state_q <= (cnt_q <= 5'd1) ? FINISH : MOVE;
        end
        MOVE: begin
          if (tick && !pause) begin
            div_q <= step_en ? '0 : div_q + 8'd1;
            if (step_en) begin
              if (!at_target) begin
                x_q <= step_x;
                y_q <= step_y;
              end else begin
                // Arrival step is the dwell: advance index, then retarget or finish.
                idx_q <= idx_q + 5'd1;
                if (last_hop) begin
                  state_q <= FINISH;
                end else begin
                  tx_q <= tgt_x;
                  ty_q <= tgt_y;
                end
              end
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign next_x   = x_q;
  assign next_y   = y_q;
  assign node_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ball_path_walker.sv
// Bench for ball_path_walker: table of whole walks checked through a position
// scoreboard, plus hand sequences for latency, restart, reset and pause.
module tb_ball_path_walker;

  localparam int unsigned N = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, reset3, tick, start, start3, pause, pause3;
  logic [4:0]      node_count;
  logic [10*N-1:0] nodes_x, nodes_y;
  logic [9:0]      next_x, next_y, next_x3, next_y3;
  logic [4:0]      node_idx, node_idx3;
  logic            busy, busy3, done, done3;

  ball_path_walker #(.NODES(N), .STEP_DIV(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .node_count(node_count), .nodes_x(nodes_x), .nodes_y(nodes_y),
    .next_x(next_x), .next_y(next_y), .node_idx(node_idx), .busy(busy), .done(done)
  );

  ball_path_walker #(.NODES(N), .STEP_DIV(3)) dut3 (
    .clk(clk), .reset(reset3), .tick(tick), .start(start3), .pause(pause3),
    .node_count(node_count), .nodes_x(nodes_x), .nodes_y(nodes_y),
    .next_x(next_x3), .next_y(next_y3), .node_idx(node_idx3), .busy(busy3), .done(done3)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(3);
  endtask

  // Scoreboard: every position change of dut while busy must match the queue head.
  logic [19:0] exp_q[$];
  logic [19:0] prev_pos;
  logic [19:0] e;
  int unsigned done_cnt = 0;
  int unsigned busy_run = 0;
  int unsigned last_busy_len = 0;

  always @(negedge clk) begin
    if (busy && ({next_x, next_y} != prev_pos)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL path_unexpected: got x=%0d y=%0d, want no move", next_x, next_y);
      end else begin
        e = exp_q.pop_front();
        chk("path_x", 32'(next_x), 32'(e[19:10]));
        chk("path_y", 32'(next_y), 32'(e[9:0]));
      end
    end
    prev_pos <= {next_x, next_y};
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      last_busy_len <= busy_run;
      busy_run      <= 0;
    end
  end

  logic [9:0] cur_x = '0;
  logic [9:0] cur_y = '0;

  task automatic push_trace(input logic [4:0] cnt, input logic [10*N-1:0] xs,
                            input logic [10*N-1:0] ys);
    int unsigned n;
    logic [9:0] px, py, gx, gy;
    n = (32'(cnt) > N) ? N : 32'(cnt);
    if (n == 0) return;
    px = xs[9:0];
    py = ys[9:0];
    if ({px, py} != {cur_x, cur_y}) exp_q.push_back({px, py});
    for (int unsigned k = 1; k < n; k++) begin
      gx = xs[10*k +: 10];
      gy = ys[10*k +: 10];
      while (px != gx || py != gy) begin
        if (px < gx) px++; else if (px > gx) px--;
        if (py < gy) py++; else if (py > gy) py--;
        exp_q.push_back({px, py});
      end
    end
  endtask

  typedef struct {
    logic [4:0]      cnt;
    logic [10*N-1:0] xs;
    logic [10*N-1:0] ys;
    int unsigned     ticks;
    logic [9:0]      fx, fy;
    logic [4:0]      fidx;
  } vec_t;

  vec_t vecs[6];

  task automatic set_node(input int unsigned v, input int unsigned k,
                          input logic [9:0] x, input logic [9:0] y);
    vecs[v].xs[10*k +: 10] = x;
    vecs[v].ys[10*k +: 10] = y;
  endtask

  task automatic set_vec(input int unsigned v, input logic [4:0] cnt, input int unsigned ticks,
                         input logic [9:0] fx, input logic [9:0] fy, input logic [4:0] fidx);
    vecs[v].cnt   = cnt;
    vecs[v].xs    = '0;
    vecs[v].ys    = '0;
    vecs[v].ticks = ticks;
    vecs[v].fx    = fx;
    vecs[v].fy    = fy;
    vecs[v].fidx  = fidx;
  endtask

  task automatic run_vec(input int unsigned i);
    int unsigned d0, ticks;
    nodes_x    = vecs[i].xs;
    nodes_y    = vecs[i].ys;
    node_count = vecs[i].cnt;
    push_trace(vecs[i].cnt, vecs[i].xs, vecs[i].ys);
    d0    = done_cnt;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    ticks = 0;
    while (done_cnt == d0 && ticks < 200) begin
      pulse_tick();
      ticks++;
    end
    cyc(4);
    chk($sformatf("v%0d_done_pulses", i), done_cnt - d0, 1);
    chk($sformatf("v%0d_ticks", i), ticks, vecs[i].ticks);
    chk($sformatf("v%0d_final_x", i), 32'(next_x), 32'(vecs[i].fx));
    chk($sformatf("v%0d_final_y", i), 32'(next_y), 32'(vecs[i].fy));
    chk($sformatf("v%0d_node_idx", i), 32'(node_idx), 32'(vecs[i].fidx));
    chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
    if (vecs[i].ticks == 0) chk($sformatf("v%0d_busy_len", i), last_busy_len, 2);
    cur_x = vecs[i].fx;
    cur_y = vecs[i].fy;
  endtask

  int unsigned d_saved;

  initial begin
    reset = 1'b1; reset3 = 1'b1; tick = 1'b0; start = 1'b0; start3 = 1'b0;
    pause = 1'b0; pause3 = 1'b0; node_count = '0; nodes_x = '0; nodes_y = '0;

    // cnt, ticks to completion, final x/y, final node_idx
    set_vec(0, 5'd2, 4, 10'd13, 10'd8, 5'd1);
    set_node(0, 0, 10'd10, 10'd10); set_node(0, 1, 10'd13, 10'd8);
    set_vec(1, 5'd1, 0, 10'd100, 10'd50, 5'd0);
    set_node(1, 0, 10'd100, 10'd50);
    set_vec(2, 5'd0, 0, 10'd100, 10'd50, 5'd0);
    set_node(2, 0, 10'd5, 10'd5);
    set_vec(3, 5'd3, 7, 10'd22, 10'd25, 5'd2);
    set_node(3, 0, 10'd20, 10'd20); set_node(3, 1, 10'd20, 10'd20); set_node(3, 2, 10'd22, 10'd25);
    set_vec(4, 5'd4, 12, 10'd50, 10'd60, 5'd3);
    set_node(4, 0, 10'd50, 10'd60); set_node(4, 1, 10'd47, 10'd60);
    set_node(4, 2, 10'd47, 10'd57); set_node(4, 3, 10'd50, 10'd60);
    set_vec(5, 5'd25, 38, 10'd319, 10'd400, 5'd19);
    for (int unsigned k = 0; k < N; k++) set_node(5, k, 10'(300 + k), 10'd400);

    cyc(3);
    reset = 1'b0; reset3 = 1'b0;
    cyc(1);
    chk("rst_next_x", 32'(next_x), 0);
    chk("rst_next_y", 32'(next_y), 0);
    chk("rst_node_idx", 32'(node_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_next_x3", 32'(next_x3), 0);

    // Latency, ignored restart in MOVE, and reset mid-walk.
    nodes_x = '0; nodes_y = '0;
    nodes_x[9:0] = 10'd10; nodes_x[19:10] = 10'd20; nodes_x[29:20] = 10'd20;
    nodes_y[9:0] = 10'd10; nodes_y[19:10] = 10'd10; nodes_y[29:20] = 10'd20;
    node_count = 5'd3;
    for (int unsigned k = 10; k <= 14; k++) exp_q.push_back({10'(k), 10'd10});
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("lat_busy_n1", 32'(busy), 1);
    chk("lat_x_n1", 32'(next_x), 0);
    cyc(1);
    chk("lat_x_n2", 32'(next_x), 10);
    chk("lat_y_n2", 32'(next_y), 10);
    chk("lat_idx_n2", 32'(node_idx), 0);
    cyc(1);
    repeat (3) pulse_tick();
    chk("mv_x3", 32'(next_x), 13);
    node_count = 5'd1;
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    node_count = 5'd3;
    chk("repulse_busy", 32'(busy), 1);
    chk("repulse_x", 32'(next_x), 13);
    pulse_tick();
    chk("repulse_step_x", 32'(next_x), 14);
    chk("repulse_step_y", 32'(next_y), 10);
    d_saved = done_cnt;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_x", 32'(next_x), 0);
    chk("midrst_y", 32'(next_y), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_idx", 32'(node_idx), 0);
    pulse_tick();
    cyc(6);
    chk("midrst_no_done", done_cnt, d_saved);
    chk("midrst_queue_drained", exp_q.size(), 0);
    cur_x = '0;
    cur_y = '0;

    for (int unsigned i = 0; i < 6; i++) run_vec(i);
    chk("table_queue_drained", exp_q.size(), 0);

    // STEP_DIV=3 instance: pause mid-count must freeze position and divider.
    nodes_x = '0; nodes_y = '0;
    nodes_x[9:0] = 10'd30; nodes_x[19:10] = 10'd40;
    nodes_y[9:0] = 10'd30; nodes_y[19:10] = 10'd30;
    node_count = 5'd2;
    start3 = 1'b1;
    cyc(1);
    start3 = 1'b0;
    cyc(3);
    chk("div3_load_x", 32'(next_x3), 30);
    for (int unsigned t = 1; t <= 4; t++) begin
      pulse_tick();
      chk($sformatf("div3_tick%0d_x", t), 32'(next_x3), (t >= 3) ? 31 : 30);
    end
    pause3 = 1'b1;
    for (int unsigned t = 0; t < 5; t++) begin
      pulse_tick();
      chk($sformatf("div3_paused%0d_x", t), 32'(next_x3), 31);
    end
    pause3 = 1'b0;
    pulse_tick();
    chk("div3_tick5_x", 32'(next_x3), 31);
    pulse_tick();
    chk("div3_tick6_x", 32'(next_x3), 32);
    chk("div3_tick6_y", 32'(next_y3), 30);
    reset3 = 1'b1;
    cyc(1);
    reset3 = 1'b0;
    chk("div3_rst_x", 32'(next_x3), 0);
    chk("div3_rst_busy", 32'(busy3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
